// File: rtl/count_bcd_display.sv
// count_bcd_display
//   Converts an 8-bit binary count to three BCD digits using a sequential
//   shift-add-3 (double-dabble) FSM. It holds the last completed result and
//   drives a 3-digit multiplexed 7-segment display with leading-zero blanking.
//   Only completed conversions reach bcd and the display, so a partially
//   converted value is never shown.
// Parameters
//   SCAN_DIV     clk cycles each digit stays lit (>= 2)
//   COMMON_ANODE 0: seg active-high, an active-low; 1: seg active-low, an active-high
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   in_val     in   8-bit binary value to convert
//   in_valid   in   sample request, honoured only while idle
//   busy       out  high while a conversion is in progress
//   bcd        out  {hundreds,tens,ones} of the last completed conversion
//   bcd_valid  out  one-cycle pulse when bcd updates
//   seg        out  segments {g,f,e,d,c,b,a} of the selected digit
//   an         out  one-hot digit select; an[0]=ones, an[1]=tens, an[2]=hundreds
module count_bcd_display #(
  parameter int SCAN_DIV     = 1000,
  parameter bit COMMON_ANODE = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_val,
  input  logic        in_valid,
  output logic        busy,
  output logic [11:0] bcd,
  output logic        bcd_valid,
  output logic [6:0]  seg,
  output logic [2:0]  an
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state;
  logic [2:0]    iter;
  logic [7:0]    bin;
  logic [11:0]   scratch;
  logic [CW-1:0] scan_cnt;
  logic [1:0]    dig;
  logic [1:0]    dig_nxt;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the shift.
  function automatic logic [11:0] add3(input logic [11:0] s);
    logic [11:0] r;
    for (int i = 0; i < 3; i++) begin
      r[i*4 +: 4] = (s[i*4 +: 4] >= 4'd5) ? s[i*4 +: 4] + 4'd3 : s[i*4 +: 4];
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Active-high pattern for digit d, with leading zeros blanked.
  function automatic logic [6:0] digit_pattern(input logic [11:0] b, input logic [1:0] d);
    case (d)
      2'd0:    return seg_decode(b[3:0]);
      2'd1:    return (b[11:8] == 4'd0 && b[7:4] == 4'd0) ? 7'h00 : seg_decode(b[7:4]);
      2'd2:    return (b[11:8] == 4'd0) ? 7'h00 : seg_decode(b[11:8]);
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [6:0] seg_pol(input logic [6:0] s);
    return COMMON_ANODE ? ~s : s;
  endfunction

  function automatic logic [2:0] an_pol(input logic [1:0] d);
    logic [2:0] onehot;
    onehot = 3'b001 << d;
    return COMMON_ANODE ? onehot : ~onehot;
  endfunction

  // Conversion control: IDLE samples, SHIFT runs 8 iterations, DONE publishes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      iter      <= 3'd0;
      bcd       <= 12'h000;
      bcd_valid <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            state <= SHIFT;
            busy  <= 1'b1;
            iter  <= 3'd0;
          end
        end
        SHIFT: begin
          iter <= iter + 3'd1;
          if (iter == 3'd7) state <= DONE;
        end
        DONE: begin
          bcd       <= scratch;
          bcd_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Conversion datapath: scratch is cleared on load, so no reset is needed.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      bin     <= in_val;
      scratch <= 12'h000;
    end else if (state == SHIFT) begin
      {scratch, bin} <= {add3(scratch), bin} << 1;
    end
  end

  always_comb begin
    dig_nxt = dig;
    if (scan_cnt == SCAN_LAST) dig_nxt = (dig == 2'd2) ? 2'd0 : dig + 2'd1;
  end

  // Display scan: seg and an are built from the next digit index so both
  // switch on the same edge the scan wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt <= '0;
      dig      <= 2'd0;
      seg      <= seg_pol(7'h3F);
      an       <= an_pol(2'd0);
    end else begin
      scan_cnt <= (scan_cnt == SCAN_LAST) ? '0 : scan_cnt + 1'b1;
      dig      <= dig_nxt;
      seg      <= seg_pol(digit_pattern(bcd, dig_nxt));
      an       <= an_pol(dig_nxt);
    end
  end

endmodule

// File: tb/tb_count_bcd_display.sv
// tb_count_bcd_display
//   Directed bench for count_bcd_display. Two instances share the stimulus:
//   dut0 (common cathode) and dut1 (common anode), both with SCAN_DIV=4.
//   Conversion results are checked through a scoreboard queue of
//   {expected bcd, expected completion cycle}.
module tb_count_bcd_display;

  localparam int SCAN = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  in_val = 8'd0;
  logic        in_valid = 1'b0;

  logic        busy0, busy1, bv0, bv1;
  logic [11:0] bcd0, bcd1;
  logic [6:0]  seg0, seg1;
  logic [2:0]  an0, an1;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int rel = 0;

  typedef struct {
    logic [11:0] val;
    int          due;
  } exp_t;
  exp_t q[$];

  count_bcd_display #(.SCAN_DIV(SCAN), .COMMON_ANODE(1'b0)) dut0 (
    .clk(clk), .reset(reset), .in_val(in_val), .in_valid(in_valid),
    .busy(busy0), .bcd(bcd0), .bcd_valid(bv0), .seg(seg0), .an(an0));

  count_bcd_display #(.SCAN_DIV(SCAN), .COMMON_ANODE(1'b1)) dut1 (
    .clk(clk), .reset(reset), .in_val(in_val), .in_valid(in_valid),
    .busy(busy1), .bcd(bcd1), .bcd_valid(bv1), .seg(seg1), .an(an1));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Edges since the last reset release: drives the expected scan position.
  always @(posedge clk or negedge reset) begin
    if (!reset) rel <= 0;
    else        rel <= rel + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] exp_seg(input logic [11:0] b, input int d);
    logic [6:0] pat [10];
    logic [3:0] h, t, o;
    pat = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    h = b[11:8];
    t = b[7:4];
    o = b[3:0];
    if (d == 0) return pat[o];
    if (d == 1) return (h == 0 && t == 0) ? 7'h00 : pat[t];
    return (h == 0) ? 7'h00 : pat[h];
  endfunction

  // Scoreboard monitor: every bcd_valid pulse must match the queue head at
  // its due cycle; a head whose due cycle has passed is a missed pulse.
  always @(negedge clk) begin
    if (reset) begin
      if (bv0) begin
        if (q.size() == 0) begin
          chk("unexpected_pulse", {31'd0, bv0}, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sb_bcd", {20'd0, bcd0}, {20'd0, e.val});
          chk("sb_latency", cyc, e.due);
        end
      end else if (q.size() > 0 && cyc > q[0].due) begin
        exp_t e;
        e = q.pop_front();
        chk("sb_missing_pulse", {31'd0, bv0}, 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scan checker for both polarities while bcd holds value b.
  task automatic check_scan(input int n, input logic [11:0] b, input string tag);
    for (int i = 0; i < n; i++) begin
      int d;
      tick();
      d = (rel / SCAN) % 3;
      chk({tag, "_an0"},  {29'd0, an0},  {29'd0, ~(3'b001 << d)});
      chk({tag, "_seg0"}, {25'd0, seg0}, {25'd0, exp_seg(b, d)});
      chk({tag, "_an1"},  {29'd0, an1},  {29'd0, (3'b001 << d)});
      chk({tag, "_seg1"}, {25'd0, seg1}, {25'd0, ~exp_seg(b, d)});
    end
  endtask

  task automatic convert(input int v);
    exp_t e;
    e.val = to_bcd(v);
    e.due = cyc + 10;
    q.push_back(e);
    in_val   = 8'(v);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    chk("conv_bcd", {20'd0, bcd0}, {20'd0, to_bcd(v)});
  endtask

  initial begin
    // Reset held: outputs at their reset values.
    repeat (3) tick();
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_bcd",  {20'd0, bcd0}, 32'd0);
    chk("rst_bv",   {31'd0, bv0}, 32'd0);
    chk("rst_seg0", {25'd0, seg0}, 32'h3F);
    chk("rst_an0",  {29'd0, an0}, 32'b110);
    chk("rst_seg1", {25'd0, seg1}, 32'h40);
    chk("rst_an1",  {29'd0, an1}, 32'b001);
    #2 reset = 1'b1;

    // T1: idle after release, digit 0 shows '0', others blank.
    check_scan(13, 12'h000, "t1");
    chk("t1_busy", {31'd0, busy0}, 32'd0);
    chk("t1_bcd",  {20'd0, bcd0}, 32'd0);

    // T2: 255, busy high for nine cycles, one pulse.
    begin
      exp_t e;
      e.val = 12'h255;
      e.due = cyc + 10;
      q.push_back(e);
      in_val   = 8'd255;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 9; i++) begin
        chk("t2_busy_hi", {31'd0, busy0}, 32'd1);
        chk("t2_bv_lo", {31'd0, bv0}, 32'd0);
        tick();
      end
      chk("t2_busy_lo", {31'd0, busy0}, 32'd0);
      chk("t2_bv_hi", {31'd0, bv0}, 32'd1);
      chk("t2_bcd", {20'd0, bcd0}, 32'h255);
      tick();
      chk("t2_bv_one", {31'd0, bv0}, 32'd0);
    end

    // T3: boundary values, display check for 9.
    convert(0);
    convert(9);
    check_scan(12, 12'h009, "t3_9");
    convert(10);
    convert(99);
    convert(100);
    convert(128);

    // T4: in_valid tied high, in_val changing every cycle.
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_val = 8'(30 + i * 7);
      if (i % 10 == 0) begin
        exp_t e;
        e.val = to_bcd(30 + i * 7);
        e.due = cyc + 10;
        q.push_back(e);
      end
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();

    // T5: reset at shift 4 of a 200 conversion.
    begin
      exp_t e;
      e.val = to_bcd(200);
      e.due = cyc + 10;
      q.push_back(e);
      in_val   = 8'd200;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (4) tick();
      chk("t5_busy_before", {31'd0, busy0}, 32'd1);
      reset = 1'b0;
      e = q.pop_back();
      #1;
      chk("t5_busy", {31'd0, busy0}, 32'd0);
      chk("t5_bv",   {31'd0, bv0}, 32'd0);
      chk("t5_bcd",  {20'd0, bcd0}, 32'd0);
      tick();
      #2 reset = 1'b1;
      convert(37);
      chk("t5_bcd37", {20'd0, bcd0}, 32'h037);
    end

    // T6: 123 scanned through all three digits on both polarities.
    convert(123);
    check_scan(14, 12'h123, "t6");

    repeat (3) tick();
    chk("sb_empty", q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
